// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I sequencing controller.
// Datapath select codes mirror the mux/ALU encodings of the core datapath.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_FAULT
    } state_t;

    // ALU decoder operating class
    localparam logic [1:0] ALU_CLASS_ADD = 2'b00;
    localparam logic [1:0] ALU_CLASS_SUB = 2'b01;
    localparam logic [1:0] ALU_CLASS_R   = 2'b10;
    localparam logic [1:0] ALU_CLASS_I   = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the controller's ALU class plus funct fields to an ALU operation,
// and flags funct encodings the core does not implement.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       legal
);

    logic is_r;

    assign is_r = (alu_class == ALU_CLASS_R);

    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b1;
        case (alu_class)
            ALU_CLASS_ADD: alu_control = ALU_ADD;
            ALU_CLASS_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: legal = 1'b0;
                endcase
                // Only add/sub distinguishes on funct7b5 for register ops
                if (is_r && funct7b5 && (funct3 != 3'b000)) begin
                    legal = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: drives shared memory port,
// shared ALU and IR/OldPC/ALUOut enables cycle by cycle, with timeout and retire counters.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [6:0]       Op,
    input  logic [2:0]       Funct3,
    input  logic             Funct7b5,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic [1:0]       ResultSrc,
    output logic             InstrDone,
    output logic [CNT_W-1:0] RetireCount,
    output logic             Fault
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retire_q, retire_d;

    logic       mem_req, mem_write, ir_write, pc_write, reg_write, instr_done, mem_wait;
    logic [1:0] alu_class;
    logic [2:0] dec_control;
    logic       dec_legal;

    always_comb begin
        alu_class = ALU_CLASS_ADD;
        case (state_q)
            S_DECODE: begin
                if (Op == OP_RTYPE) begin
                    alu_class = ALU_CLASS_R;
                end else if (Op == OP_ITYPE) begin
                    alu_class = ALU_CLASS_I;
                end
            end
            S_EXECR:  alu_class = ALU_CLASS_R;
            S_EXECI:  alu_class = ALU_CLASS_I;
            S_BRANCH: alu_class = ALU_CLASS_SUB;
            default:  alu_class = ALU_CLASS_ADD;
        endcase
    end

    mc_alu_decoder u_alu_dec (
        .alu_class   (alu_class),
        .funct3      (Funct3),
        .funct7b5    (Funct7b5),
        .alu_control (dec_control),
        .legal       (dec_legal)
    );

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUControl = dec_control;
        ImmSrc     = IMM_I;
        ResultSrc  = RES_ALUOUT;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures the branch target while the opcode is examined
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_B;
                ALUControl = ALU_ADD;
                case (Op)
                    OP_LOAD, OP_STORE: state_d = (Funct3 == 3'b010) ? S_MEMADR : S_FAULT;
                    OP_RTYPE:  state_d = dec_legal ? S_EXECR : S_FAULT;
                    OP_ITYPE:  state_d = dec_legal ? S_EXECI : S_FAULT;
                    OP_BRANCH: state_d = (Funct3[2:1] == 2'b00) ? S_BRANCH : S_FAULT;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    default:   state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (Op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_MEMDATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                AdrSrc    = 1'b1;
                if (MemReady) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                pc_write   = Zero ^ Funct3[0];
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JAL;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while ALU forms the link value
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_d = S_ALUWB;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        mem_wait = mem_req & ~MemReady;
        if ((MEM_TIMEOUT > 0) && mem_wait && (wait_q == WAIT_LAST)) begin
            state_d = S_FAULT;
        end
        wait_d   = (mem_wait && (state_d == state_q)) ? wait_q + 1'b1 : '0;
        retire_d = retire_q + CNT_W'(instr_done);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_FETCH;
            wait_q   <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
        end
    end

    // Enables are gated directly by Reset so an access aborts without waiting for a clock
    assign MemReq      = mem_req & Reset;
    assign MemWrite    = mem_write & Reset;
    assign IRWrite     = ir_write & Reset;
    assign PCWrite     = pc_write & Reset;
    assign RegWrite    = reg_write & Reset;
    assign InstrDone   = instr_done & Reset;
    assign RetireCount = retire_q;
    assign Fault       = (state_q == S_FAULT);

endmodule
